// File: rtl/uart_pkt_pkg.sv
// Shared definitions for the UART packet receiver: FSM encodings, default SOF marker
// and the bit positions of the error vector.
package uart_pkt_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LEN     = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_CHECK   = 3'd3;
    localparam logic [2:0] ST_DELIVER = 3'd4;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    // Bit positions within the registered error-pulse vector
    localparam int unsigned ERR_LEN     = 0;
    localparam int unsigned ERR_CHK     = 1;
    localparam int unsigned ERR_BYTE    = 2;
    localparam int unsigned ERR_TIMEOUT = 3;
    localparam int unsigned ERR_OVERRUN = 4;
    localparam int unsigned ERR_W       = 5;

endpackage

// File: rtl/uart_packet_rx_if.sv
// Byte stream from the UART receiver plus the valid/ready payload stream to the host.
interface uart_packet_rx_if;

    logic       byte_valid;
    logic [7:0] byte_data;
    logic [2:0] byte_err;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    modport slave (
        input  byte_valid, byte_data, byte_err, out_ready,
        output out_valid, out_data, out_last
    );

    modport master (
        output byte_valid, byte_data, byte_err, out_ready,
        input  out_valid, out_data, out_last
    );

endinterface

// File: rtl/uart_pkt_buf.sv
// Payload buffer: synchronous write, asynchronous read, storage is not reset.
module uart_pkt_buf #(
    parameter  int unsigned MAX_LEN = 16,
    localparam int unsigned AW      = $clog2(MAX_LEN + 1),
    localparam int unsigned IW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data_c
);

    logic [7:0] mem [MAX_LEN];

    always_ff @(posedge clk) begin
        if (wr_en) mem[IW'(wr_addr)] <= wr_data;
    end

    assign rd_data_c = mem[IW'(rd_addr)];

endmodule

// File: rtl/uart_packet_rx.sv
// Frames UART bytes into SOF/LEN/payload/CHK packets, verifies them and replays
// good payloads to the host; bad packets are dropped with a one-cycle error pulse.
module uart_packet_rx
    import uart_pkt_pkg::*;
#(
    parameter int unsigned MAX_LEN     = 16,
    parameter logic [7:0]  SOF_BYTE    = SOF_DEFAULT,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic              clock,
    input  logic              reset_n,
    uart_packet_rx_if.slave   bus,
    output logic              busy,
    output logic              err_len,
    output logic              err_chk,
    output logic              err_byte,
    output logic              err_timeout,
    output logic              err_overrun,
    output logic [15:0]       pkt_count
);

    localparam int unsigned AW        = $clog2(MAX_LEN + 1);
    localparam int unsigned TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT_CYC);

    logic [2:0]       state_q, state_d;
    logic [AW-1:0]    len_q, len_d, wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, rd_addr_c;
    logic [7:0]       chk_q, chk_d, out_data_q, out_data_d, rd_data_c;
    logic             out_valid_q, out_valid_d, out_last_q, out_last_d, busy_q, busy_d;
    logic [TW-1:0]    tmo_q, tmo_d, tmo_inc_c;
    logic [ERR_W-1:0] err_q, err_d;
    logic [15:0]      pkt_q, pkt_d;
    logic             wr_en_c, accept_c, bad_byte_c, in_pkt_c;

    uart_pkt_buf #(.MAX_LEN(MAX_LEN)) u_buf (
        .clk       (clock),
        .wr_en     (wr_en_c),
        .wr_addr   (wr_idx_q),
        .wr_data   (bus.byte_data),
        .rd_addr   (rd_addr_c),
        .rd_data_c (rd_data_c)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        chk_d       = chk_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        pkt_d       = pkt_q;
        err_d       = '0;
        wr_en_c     = 1'b0;
        rd_addr_c   = AW'(rd_idx_q + 1'b1);

        accept_c   = bus.byte_valid && (bus.byte_err == 3'b000);
        bad_byte_c = bus.byte_valid && (bus.byte_err != 3'b000);
        in_pkt_c   = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);
        tmo_inc_c  = (tmo_q == TMO_LIM) ? tmo_q : TW'(tmo_q + 1'b1);
        tmo_d      = (in_pkt_c && !bus.byte_valid) ? tmo_inc_c : '0;

        case (state_q)
            ST_IDLE: begin
                if (accept_c && bus.byte_data == SOF_BYTE) state_d = ST_LEN;
            end
            ST_LEN: begin
                if (accept_c) begin
                    if (bus.byte_data == 8'h00 || bus.byte_data > MAX_LEN_B) begin
                        err_d[ERR_LEN] = 1'b1;
                        state_d        = ST_IDLE;
                    end else begin
                        len_d    = AW'(bus.byte_data);
                        chk_d    = bus.byte_data;
                        wr_idx_d = '0;
                        state_d  = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (accept_c) begin
                    wr_en_c  = 1'b1;
                    chk_d    = chk_q ^ bus.byte_data;
                    wr_idx_d = AW'(wr_idx_q + 1'b1);
                    if (wr_idx_d == len_q) state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // First payload byte is preloaded so out_valid rises one clock after CHK
                if (accept_c) begin
                    if (bus.byte_data == chk_q) begin
                        rd_idx_d    = '0;
                        rd_addr_c   = '0;
                        out_valid_d = 1'b1;
                        out_data_d  = rd_data_c;
                        out_last_d  = (len_q == AW'(1));
                        state_d     = ST_DELIVER;
                    end else begin
                        err_d[ERR_CHK] = 1'b1;
                        state_d        = ST_IDLE;
                    end
                end
            end
            ST_DELIVER: begin
                if (bus.byte_valid) err_d[ERR_OVERRUN] = 1'b1;
                if (out_valid_q && bus.out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_data_d  = 8'h00;
                        pkt_d       = 16'(pkt_q + 1'b1);
                        state_d     = ST_IDLE;
                    end else begin
                        rd_idx_d   = AW'(rd_idx_q + 1'b1);
                        out_data_d = rd_data_c;
                        out_last_d = (AW'(rd_idx_q + 1'b1) == AW'(len_q - 1'b1));
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A byte landing on the expiry cycle keeps the packet alive
        if (in_pkt_c && !bus.byte_valid && tmo_inc_c == TMO_LIM) begin
            err_d[ERR_TIMEOUT] = 1'b1;
            state_d            = ST_IDLE;
        end

        if (bad_byte_c && state_q != ST_DELIVER) begin
            err_d[ERR_BYTE] = 1'b1;
            state_d         = ST_IDLE;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            len_q       <= '0;
            chk_q       <= '0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            tmo_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= '0;
            pkt_q       <= '0;
        end else begin
            len_q       <= len_d;
            chk_q       <= chk_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            tmo_q       <= tmo_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            pkt_q       <= pkt_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign busy          = busy_q;
    assign err_len       = err_q[ERR_LEN];
    assign err_chk       = err_q[ERR_CHK];
    assign err_byte      = err_q[ERR_BYTE];
    assign err_timeout   = err_q[ERR_TIMEOUT];
    assign err_overrun   = err_q[ERR_OVERRUN];
    assign pkt_count     = pkt_q;

endmodule

// File: tb/tb_uart_packet_rx.sv
// Scoreboard bench for uart_packet_rx: directed packets, expected payload bytes and
// error pulses (with their expected cycle) are queued and checked by a monitor.
module tb_uart_packet_rx;
    import uart_pkt_pkg::*;

    localparam int unsigned MAX_LEN     = 16;
    localparam int unsigned TIMEOUT_CYC = 50;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } out_t;

    typedef struct {
        int kind;
        int cyc;
    } err_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        busy, err_len, err_chk, err_byte, err_timeout, err_overrun;
    logic [15:0] pkt_count;

    uart_packet_rx_if bus();

    uart_packet_rx #(
        .MAX_LEN     (MAX_LEN),
        .SOF_BYTE    (8'hA5),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus         (bus),
        .busy        (busy),
        .err_len     (err_len),
        .err_chk     (err_chk),
        .err_byte    (err_byte),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun),
        .pkt_count   (pkt_count)
    );

    always #5 clock = ~clock;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    out_t exp_out[$];
    err_t exp_err[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Drive one byte for one clock; caller is aligned to a falling edge
    task automatic send(input logic [7:0] d, input logic [2:0] e = 3'b000);
        bus.byte_valid = 1'b1;
        bus.byte_data  = d;
        bus.byte_err   = e;
        @(negedge clock);
        bus.byte_valid = 1'b0;
        bus.byte_err   = 3'b000;
    endtask

    // Expect an error pulse caused by the byte about to be sent, plus extra clocks
    task automatic expect_err(input int kind, input int extra = 0);
        err_t e;
        e.kind = kind;
        e.cyc  = cyc + 1 + extra;
        exp_err.push_back(e);
    endtask

    task automatic expect_out(input logic [7:0] d, input logic l);
        out_t o;
        o.d = d;
        o.l = l;
        exp_out.push_back(o);
    endtask

    task automatic wait_done(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            #3;
            if (!busy && exp_out.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check(name, 32'(done), 32'd1);
        @(negedge clock);
    endtask

    // Monitor: payload transfers and error pulses, sampled mid low phase
    always begin
        logic [ERR_W-1:0] errv;
        out_t o;
        err_t e;
        @(negedge clock);
        #2;
        if (reset_n) begin
            if (bus.out_valid && bus.out_ready) begin
                n_cmp++;
                if (exp_out.size() == 0) begin
                    n_fail++;
                    $display("FAIL out_unexpected: got data %h last %b, required no transfer (cycle %0d)",
                             bus.out_data, bus.out_last, cyc);
                end else begin
                    o = exp_out.pop_front();
                    if (bus.out_data !== o.d || bus.out_last !== o.l) begin
                        n_fail++;
                        $display("FAIL out_byte: got data %h last %b, required data %h last %b",
                                 bus.out_data, bus.out_last, o.d, o.l);
                    end
                end
            end
            errv = '0;
            errv[ERR_LEN]     = err_len;
            errv[ERR_CHK]     = err_chk;
            errv[ERR_BYTE]    = err_byte;
            errv[ERR_TIMEOUT] = err_timeout;
            errv[ERR_OVERRUN] = err_overrun;
            for (int k = 0; k < int'(ERR_W); k++) begin
                if (errv[k]) begin
                    n_cmp++;
                    if (exp_err.size() == 0) begin
                        n_fail++;
                        $display("FAIL err_unexpected: got error bit %0d at cycle %0d, required none", k, cyc);
                    end else begin
                        e = exp_err.pop_front();
                        if (e.kind != k || e.cyc != cyc) begin
                            n_fail++;
                            $display("FAIL err_pulse: got bit %0d at cycle %0d, required bit %0d at cycle %0d",
                                     k, cyc, e.kind, e.cyc);
                        end
                    end
                end
            end
        end
    end

    initial begin
        reset_n        = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        bus.byte_err   = 3'b000;
        bus.out_ready  = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pkt_count", 32'(pkt_count), 32'd0);
        check("rst_errs", 32'({err_len, err_chk, err_byte, err_timeout, err_overrun}), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // Good packet, single-clock latency to first out_valid
        expect_out(8'h11, 1'b0); expect_out(8'h22, 1'b0); expect_out(8'h33, 1'b1);
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        check("busy_mid_pkt", 32'(busy), 32'd1);
        send(8'h03);
        check("first_latency", 32'(bus.out_valid), 32'd1);
        wait_done("drain_good");
        check("pkt_count_1", 32'(pkt_count), 32'd1);

        // Bad checksum (correct value FD), then a good one-byte packet
        send(8'hA5); send(8'h02); send(8'hAA); send(8'h55);
        expect_err(ERR_CHK);
        send(8'h00);
        expect_out(8'h42, 1'b1);
        send(8'hA5); send(8'h01); send(8'h42); send(8'h43);
        wait_done("drain_after_chk");
        check("pkt_count_2", 32'(pkt_count), 32'd2);

        // Length 0 and length MAX_LEN+1
        send(8'hA5); expect_err(ERR_LEN); send(8'h00);
        @(negedge clock);
        check("busy_after_len0", 32'(busy), 32'd0);
        send(8'hA5); expect_err(ERR_LEN); send(8'h11);
        @(negedge clock);
        check("busy_after_len17", 32'(busy), 32'd0);
        expect_out(8'h7E, 1'b1);
        send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
        wait_done("drain_after_len");
        check("pkt_count_3", 32'(pkt_count), 32'd3);

        // Backpressure with an overrun byte injected during delivery
        bus.out_ready = 1'b0;
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
        expect_err(ERR_OVERRUN);
        send(8'h5A);
        for (int i = 0; i < 4; i++) begin
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_data", 32'(bus.out_data), 32'h11);
            check("hold_last", 32'(bus.out_last), 32'd0);
            @(negedge clock);
        end
        expect_out(8'h11, 1'b0); expect_out(8'h22, 1'b0); expect_out(8'h33, 1'b1);
        bus.out_ready = 1'b1;
        wait_done("drain_backpressure");
        check("pkt_count_4", 32'(pkt_count), 32'd4);

        // Inter-byte timeout after the first payload byte
        send(8'hA5); send(8'h04);
        expect_err(ERR_TIMEOUT, int'(TIMEOUT_CYC));
        send(8'h11);
        repeat (TIMEOUT_CYC - 3) @(negedge clock);
        check("busy_before_timeout", 32'(busy), 32'd1);
        repeat (5) @(negedge clock);
        check("busy_after_timeout", 32'(busy), 32'd0);
        expect_out(8'h7E, 1'b1);
        send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
        wait_done("drain_after_timeout");
        check("pkt_count_5", 32'(pkt_count), 32'd5);

        // Receiver error flag on a payload byte
        send(8'hA5); send(8'h03); send(8'h11);
        expect_err(ERR_BYTE);
        send(8'h22, 3'b100);
        check("busy_after_byte_err", 32'(busy), 32'd0);

        // Reset asserted in the middle of delivery
        bus.out_ready = 1'b0;
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
        check("deliver_before_reset", 32'(bus.out_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_pkt_count", 32'(pkt_count), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clock);
        expect_out(8'h7E, 1'b1);
        send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
        wait_done("drain_after_reset");
        check("pkt_count_after_reset", 32'(pkt_count), 32'd1);

        repeat (3) @(negedge clock);
        check("pending_out", 32'(exp_out.size()), 32'd0);
        check("pending_err", 32'(exp_err.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_packet_rx.md
Name: uart_packet_rx

Overview:
Downstream consumer of the duplex UART receive path. It takes the byte stream and per-byte error flags delivered by the UART receiver and frames them into packets of the form SOF, LEN, payload[LEN], CHK. It validates the length, per-byte errors, the inter-byte timeout and the XOR checksum. Verified payloads are buffered and replayed to the host over a valid/ready stream; bad packets are dropped and reported through one-cycle error pulses.

Parameters:
MAX_LEN, 16, maximum payload bytes per packet (2..255); also the depth of the payload buffer.
SOF_BYTE, 8'hA5, start-of-frame marker.
TIMEOUT_CYC, 100000, idle clocks allowed between bytes inside a packet before it is abandoned (>=2).

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
byte_valid  in  1  one-cycle pulse: a received byte is present on byte_data
byte_data  in  8  received byte
byte_err  in  3  receiver error flags {parity, start, stop} qualified by byte_valid
out_valid  out  1  payload byte available
out_ready  in  1  host accepts the payload byte
out_data  out  8  payload byte
out_last  out  1  marks the final payload byte of the packet
busy  out  1  high in every state except IDLE
err_len  out  1  pulse: LEN is 0 or greater than MAX_LEN
err_chk  out  1  pulse: checksum mismatch
err_byte  out  1  pulse: a byte arrived with a nonzero byte_err
err_timeout  out  1  pulse: inter-byte timeout expired
err_overrun  out  1  pulse: a byte arrived while in DELIVER
pkt_count  out  16  count of good packets delivered; wraps at 16'hFFFF->0

Behaviour:
- Reset: state=IDLE. All outputs 0, including pkt_count. The buffer contents are don't-care. Reset takes effect immediately, including mid-packet or mid-delivery; any partial packet is discarded.
- Accepted byte: byte_valid=1 and byte_err=0.
- Any byte_valid with byte_err!=0, in any state other than DELIVER:
  - err_byte pulses on the next cycle.
  - State returns to IDLE.
- State IDLE:
  - Accepted byte == SOF_BYTE -> LEN.
  - Any other byte is discarded silently.
- State LEN, on an accepted byte:
  - LEN==0 or LEN>MAX_LEN -> err_len pulse, go to IDLE.
  - Otherwise latch len, set chk_acc=LEN, clear wr_idx, go to PAYLOAD.
- State PAYLOAD, on each accepted byte:
  - buf[wr_idx]=byte; chk_acc^=byte; wr_idx++.
  - When wr_idx reaches len -> CHECK.
- State CHECK, on an accepted byte:
  - byte==chk_acc -> DELIVER, with rd_idx=0.
  - Otherwise err_chk pulse, go to IDLE.
- Timeout:
  - Counter is cleared on every byte_valid and in IDLE/DELIVER.
  - It increments each clock in LEN, PAYLOAD and CHECK.
  - On reaching TIMEOUT_CYC: err_timeout pulse, go to IDLE. This is exactly TIMEOUT_CYC clocks after the last byte_valid.
  - A byte_valid arriving on the expiry cycle wins; the counter clears.
- State DELIVER:
  - out_valid=1 starting the cycle after the CHK byte. Latency from CHK byte to first out_valid is 1 clock.
  - out_data=buf[rd_idx]; out_last=(rd_idx==len-1).
  - A transfer occurs when out_valid && out_ready; rd_idx then increments.
  - out_data and out_last stay stable while out_valid && !out_ready.
  - On the transfer with out_last=1: the next state is IDLE, out_valid drops, and pkt_count increments on the same edge.
  - Back-to-back transfers sustain 1 byte/clock.
- Overrun: any byte_valid in DELIVER is dropped and err_overrun pulses, regardless of byte_err. A SOF arriving in DELIVER is therefore lost.
- Error pulse timing: each error pulse is registered, lasting exactly 1 clock in the cycle after its cause. Only one error can occur per cycle.
- Width rules:
  - Index widths are $clog2(MAX_LEN+1).
  - chk_acc is 8 bits, XOR only.
  - The timeout counter is $clog2(TIMEOUT_CYC+1) bits and saturates.

Decomposition:
- Shared package uart_pkt_pkg holds:
  - state enum {IDLE, LEN, PAYLOAD, CHECK, DELIVER};
  - the default SOF constant 8'hA5;
  - the error-vector bit indices used by the status register map.
- One sub-module, uart_pkt_buf: MAX_LEN x 8 storage, one synchronous write port, one asynchronous read port, no reset on storage.

Test Plan:
1. Good packet, byte stream A5 03 11 22 33 03 -> out_data 11,22,33 with out_last on 33; pkt_count 0->1; no error pulses.
2. Bad checksum, byte stream A5 02 AA 55 00 (correct CHK is FD) -> err_chk pulses once; out_valid never asserts; a following good packet is delivered normally.
3. Length errors: A5 00, then A5 11 with MAX_LEN=16 -> err_len on each; busy returns to 0; then A5 01 7E 7F delivers 7E.
4. Backpressure and overrun: hold out_ready=0 for 5 clocks during packet 1 and inject byte_valid=5A -> out_data holds 11; err_overrun pulses; 5A does not appear on the output.
5. Timeout, TIMEOUT_CYC=50: send A5 04 11 then go silent -> err_timeout exactly 50 clocks after 11; IDLE; a next packet is accepted.
6. Byte error and reset: byte_err=3'b100 on a payload byte -> err_byte, IDLE. Assert reset_n low mid-DELIVER -> out_valid=0 and pkt_count=0 immediately.
